// File: rtl/ram_request_unit.sv
// Data-port controller for the shared 4096x32 RAM: byte/half/word loads and stores, with sub-word stores done as read-modify-write.
// Optional build macro: MEM_MISALIGN_CHECK_EN flags misaligned halfword/word accesses as errors.
module ram_request_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [11:0] ram_address_data,
   output logic [31:0] ram_data_in,
   output logic        ram_write_enable,
   input  logic [31:0] ram_rdata
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]  r_state;
   logic        r_we, r_uns, r_err;
   logic [1:0]  r_size, r_lane;
   logic [31:0] r_wdata, r_rdata, r_data_in;
   logic [11:0] r_addr;

   logic        w_accept, w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load, w_merge;
   logic        w_unused_addr;

   assign w_unused_addr = ^req_addr[31:14];
   assign w_accept      = req_valid && (r_state == S_IDLE);

`ifdef MEM_MISALIGN_CHECK_EN
   assign w_err = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign w_err = (req_size == 2'b11);
`endif

   // Lane extraction and merge both operate on the word captured from the RAM
   always_comb begin
      w_byte  = ram_rdata[{r_lane, 3'b000} +: 8];
      w_half  = r_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      w_load  = ram_rdata;
      w_merge = ram_rdata;
      case (r_size)
         2'b00: begin
            w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
         end
         2'b01: begin
            w_load = {{16{~r_uns & w_half[15]}}, w_half};
            if (r_lane[1]) w_merge[31:16] = r_wdata[15:0];
            else           w_merge[15:0]  = r_wdata[15:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_uns     <= 1'b0;
         r_err     <= 1'b0;
         r_size    <= 2'b00;
         r_lane    <= 2'b00;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_data_in <= '0;
         r_addr    <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_we    <= req_we;
               r_uns   <= req_unsigned;
               r_size  <= req_size;
               r_lane  <= req_addr[1:0];
               r_wdata <= req_wdata;
               if (w_err) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_err  <= 1'b0;
                  r_addr <= req_addr[13:2];
                  if (req_we && (req_size == 2'b10)) begin
                     r_data_in <= req_wdata;
                     r_state   <= S_WRITE;
                  end else begin
                     r_state <= S_READ;
                  end
               end
            end
            S_READ:    r_state <= S_CAPTURE;
            S_CAPTURE: begin
               if (r_we) begin
                  r_data_in <= w_merge;
                  r_state   <= S_WRITE;
               end else begin
                  r_rdata <= w_load;
                  r_state <= S_DONE;
               end
            end
            S_WRITE: begin
               r_rdata <= '0;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write strobe decoded from state so an async reset drops it immediately
   assign req_ready        = (r_state == S_IDLE);
   assign rsp_valid        = (r_state == S_DONE);
   assign rsp_err          = (r_state == S_DONE) && r_err;
   assign rsp_rdata        = r_rdata;
   assign ram_address_data = r_addr;
   assign ram_data_in      = r_data_in;
   assign ram_write_enable = (r_state == S_WRITE);

endmodule

// File: tb/tb_ram_request_unit.sv
// Directed bench for ram_request_unit with a behavioural 4096x32 registered-read RAM.
module tb_ram_request_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [11:0] ram_address_data;
   logic [31:0] ram_data_in;
   logic        ram_write_enable;
   logic [31:0] ram_rdata = '0;

   logic [31:0] mem [4096];
   int n_cmp = 0;
   int n_err = 0;

   ram_request_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_address_data(ram_address_data), .ram_data_in(ram_data_in),
      .ram_write_enable(ram_write_enable), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_address_data] <= ram_data_in;
      ram_rdata <= mem[ram_address_data];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Issue one request and follow it to its response (bounded), recording writes.
   task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int nwr, output logic [11:0] wa, output logic [31:0] wdv);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; rd = '0; er = 1'b0; nwr = 0; wa = '0; wdv = '0;
      for (int i = 1; i <= 20; i++) begin
         if (ram_write_enable) begin nwr++; wa = ram_address_data; wdv = ram_data_in; end
         if (rsp_valid) begin lat = i; rd = rsp_rdata; er = rsp_err; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int lat, nwr;
      logic [31:0] rd, wdv;
      logic er;
      logic [11:0] wa;

      for (int i = 0; i < 4096; i++) mem[i] = '0;
      #2;
      chk("rst.ready", req_ready, 1);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.rdata", rsp_rdata, 0);
      chk("rst.err", rsp_err, 0);
      chk("rst.addr", ram_address_data, 0);
      chk("rst.din", ram_data_in, 0);
      chk("rst.we", ram_write_enable, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, rd, er, nwr, wa, wdv);
      chk("wst.lat", lat, 2);
      chk("wst.nwr", nwr, 1);
      chk("wst.addr", wa, 12'd4);
      chk("wst.data", wdv, 32'hDEADBEEF);
      chk("wst.err", er, 0);
      chk("wst.mem", mem[4], 32'hDEADBEEF);

      xact(0, 2'b10, 0, 32'h10, 0, lat, rd, er, nwr, wa, wdv);
      chk("wld.lat", lat, 3);
      chk("wld.data", rd, 32'hDEADBEEF);
      chk("wld.err", er, 0);
      chk("wld.nwr", nwr, 0);
      chk("wld.hold", rsp_rdata, 32'hDEADBEEF);

      xact(1, 2'b00, 0, 32'h12, 32'h0000005A, lat, rd, er, nwr, wa, wdv);
      chk("bst.lat", lat, 4);
      chk("bst.nwr", nwr, 1);
      chk("bst.data", wdv, 32'hDE5ABEEF);
      chk("bst.rdata", rd, 0);
      chk("bst.mem", mem[4], 32'hDE5ABEEF);

      xact(0, 2'b00, 0, 32'h13, 0, lat, rd, er, nwr, wa, wdv);
      chk("lb.lat", lat, 3);
      chk("lb.data", rd, 32'hFFFFFFDE);
      xact(0, 2'b00, 1, 32'h13, 0, lat, rd, er, nwr, wa, wdv);
      chk("lbu.data", rd, 32'h000000DE);

      xact(0, 2'b01, 0, 32'h10, 0, lat, rd, er, nwr, wa, wdv);
      chk("lh.data", rd, 32'hFFFFBEEF);
      xact(0, 2'b01, 1, 32'h12, 0, lat, rd, er, nwr, wa, wdv);
      chk("lhu.data", rd, 32'h0000DE5A);

      xact(0, 2'b10, 0, 32'h11, 0, lat, rd, er, nwr, wa, wdv);
`ifdef MEM_MISALIGN_CHECK_EN
      chk("mis.lat", lat, 1);
      chk("mis.err", er, 1);
      chk("mis.data", rd, 0);
`else
      chk("mis.lat", lat, 3);
      chk("mis.err", er, 0);
      chk("mis.data", rd, 32'hDE5ABEEF);
`endif
      chk("mis.nwr", nwr, 0);

      xact(0, 2'b11, 0, 32'h10, 0, lat, rd, er, nwr, wa, wdv);
      chk("rsv.lat", lat, 1);
      chk("rsv.err", er, 1);
      chk("rsv.data", rd, 0);
      xact(1, 2'b11, 0, 32'h10, 32'h11111111, lat, rd, er, nwr, wa, wdv);
      chk("rsvst.err", er, 1);
      chk("rsvst.nwr", nwr, 0);
      chk("rsvst.mem", mem[4], 32'hDE5ABEEF);

      xact(1, 2'b10, 0, 32'h4000, 32'h12345678, lat, rd, er, nwr, wa, wdv);
      chk("wrap.addr", wa, 12'd0);
      chk("wrap.mem", mem[0], 32'h12345678);

      xact(1, 2'b01, 0, 32'h6, 32'h0000A5A5, lat, rd, er, nwr, wa, wdv);
      chk("hst.lat", lat, 4);
      chk("hst.data", wdv, 32'hA5A50000);
      chk("hst.mem", mem[1], 32'hA5A50000);

      // Reset during WRITE of a word store
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mid.we_before", ram_write_enable, 1);
      rst = 1'b1; #1;
      chk("mid.we_after", ram_write_enable, 0);
      chk("mid.ready", req_ready, 1);
      @(posedge clk); #1;
      chk("mid.rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      chk("mid.rsp_valid2", rsp_valid, 0);
      chk("mid.mem", mem[8], 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid.ready_rel", req_ready, 1);
      chk("mid.rsp_valid3", rsp_valid, 0);

      xact(0, 2'b10, 0, 32'h20, 0, lat, rd, er, nwr, wa, wdv);
      chk("post.data", rd, 0);
      xact(0, 2'b10, 0, 32'h0, 0, lat, rd, er, nwr, wa, wdv);
      chk("post.wrap", rd, 32'h12345678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
